// File: rtl/fc_pkg.sv
// Shared definitions for the fast-control sequencer: FC bit positions and default widths.
package fc_pkg;

   localparam int unsigned FC_BCR          = 0;
   localparam int unsigned FC_L1A          = 1;
   localparam int unsigned FC_LINK_RESET   = 2;
   localparam int unsigned FC_BUFFER_CLEAR = 3;

   localparam int unsigned FC_BITS_DEF = 8;
   localparam int unsigned NUM_CMD_DEF = 3;
   localparam int unsigned BX_W_DEF    = 12;
   localparam int unsigned PER_W_DEF   = 24;
   localparam int unsigned DT_W_DEF    = 8;

endpackage

// File: rtl/fc_cmd_channel.sv
// One non-L1A command channel: pending latch plus BX-match firing logic.
module fc_cmd_channel
   import fc_pkg::*;
#(
   parameter int unsigned BX_W = BX_W_DEF
) (
   input  logic            clk_bx,
   input  logic            reset,
   input  logic            req,
   input  logic            align,
   input  logic [BX_W-1:0] target,
   input  logic [BX_W-1:0] bx,
   output logic            fire_c
);

   logic pending;
   logic match_c;

   always_comb begin
      match_c = (bx == target);
      // Dropping align releases a stored request immediately
      fire_c  = align ? ((pending | req) & match_c) : (req | pending);
   end

   always_ff @(posedge clk_bx or posedge reset) begin
      if (reset) begin
         pending <= 1'b0;
      end else begin
         pending <= align & (pending | req) & ~match_c;
      end
   end

endmodule

// File: rtl/hamming84_enc.sv
// Hamming(8,4) SECDED encoder for one nibble. Layout: bit0..6 = codeword positions 1..7
// (parity at 1,2,4; data at 3,5,6,7), bit7 = overall parity.
module hamming84_enc (
   input  logic [3:0] data,
   output logic [7:0] code_c
);

   logic p1, p2, p4;

   always_comb begin
      p1 = data[0] ^ data[1] ^ data[3];
      p2 = data[0] ^ data[2] ^ data[3];
      p4 = data[1] ^ data[2] ^ data[3];
      code_c[6:0] = {data[3], data[2], data[1], p4, data[0], p2, p1};
      code_c[7]   = ^{data[3], data[2], data[1], p4, data[0], p2, p1};
   end

endmodule

// File: rtl/fc_sequencer.sv
// Fast-control word generator: BCR, command channels, periodic L1A with busy/deadtime
// suppression, Hamming(8,4)-encoded output and status counters.
module fc_sequencer
   import fc_pkg::*;
#(
   parameter int unsigned FC_BITS = FC_BITS_DEF,
   parameter int unsigned NUM_CMD = NUM_CMD_DEF,
   parameter int unsigned BX_W    = BX_W_DEF,
   parameter int unsigned PER_W   = PER_W_DEF,
   parameter int unsigned DT_W    = DT_W_DEF
) (
   input  logic                      clk_bx,
   input  logic                      reset,
   input  logic [BX_W-1:0]           orb_length,
   input  logic [NUM_CMD-1:0]        cmd_req,
   input  logic [NUM_CMD-1:0]        cmd_align,
   input  logic [NUM_CMD*BX_W-1:0]   cmd_bx,
   input  logic [PER_W-1:0]          l1a_period,
   input  logic [DT_W-1:0]           l1a_deadtime,
   input  logic                      busy,
   input  logic [FC_BITS-2-NUM_CMD:0] aux_bits,
   output logic [2*FC_BITS-1:0]      fc_stream_enc,
   output logic [BX_W-1:0]           bx_counter,
   output logic [31:0]               orbit_count,
   output logic [31:0]               l1a_count,
   output logic [15:0]               l1a_dropped
);

   localparam int unsigned NIB = FC_BITS / 4;

   logic [FC_BITS-1:0]   fc_word;
   logic [FC_BITS-1:0]   word_c;
   logic [2*FC_BITS-1:0] enc_c;
   logic [NUM_CMD-1:1]   fire_c;
   logic [PER_W-1:0]     per_cnt;
   logic [DT_W-1:0]      dt_cnt;
   logic [BX_W-1:0]      last_bx_c;
   logic                 tick_c, cand_c, issue_c, drop_c, bcr_c;
   logic                 unused_ok;

   // Channel 0 is the L1A path and has no alignment or target BX
   assign unused_ok = ^{cmd_align[0], cmd_bx[BX_W-1:0]};

   for (genvar k = 1; k < NUM_CMD; k++) begin : g_chan
      fc_cmd_channel #(.BX_W(BX_W)) u_chan (
         .clk_bx (clk_bx),
         .reset  (reset),
         .req    (cmd_req[k]),
         .align  (cmd_align[k]),
         .target (cmd_bx[k*BX_W +: BX_W]),
         .bx     (bx_counter),
         .fire_c (fire_c[k])
      );
   end

   for (genvar n = 0; n < NIB; n++) begin : g_enc
      hamming84_enc u_enc (
         .data   (fc_word[4*n +: 4]),
         .code_c (enc_c[8*n +: 8])
      );
   end

   always_comb begin
      // orb_length 0 wraps to all-ones, giving a full 2**BX_W orbit
      last_bx_c = orb_length - BX_W'(1);
      bcr_c     = (bx_counter == '0);
      tick_c    = (l1a_period != '0) && (per_cnt >= l1a_period - PER_W'(1));
      cand_c    = cmd_req[0] | tick_c;
      issue_c   = cand_c & ~busy & (dt_cnt == '0);
      drop_c    = cand_c & ~issue_c;

      word_c         = '0;
      word_c[FC_BCR] = bcr_c;
      word_c[FC_L1A] = issue_c;
      for (int k = 1; k < NUM_CMD; k++) word_c[k+1] = fire_c[k];
      word_c[FC_BITS-1:NUM_CMD+1] = aux_bits;
   end

   always_ff @(posedge clk_bx or posedge reset) begin
      if (reset) begin
         bx_counter    <= '0;
         per_cnt       <= '0;
         dt_cnt        <= '0;
         fc_word       <= '0;
         fc_stream_enc <= '0;
         orbit_count   <= '0;
         l1a_count     <= '0;
         l1a_dropped   <= '0;
      end else begin
         bx_counter    <= (bx_counter >= last_bx_c) ? '0 : bx_counter + BX_W'(1);
         per_cnt       <= tick_c ? '0 : per_cnt + PER_W'(1);
         fc_word       <= word_c;
         fc_stream_enc <= enc_c;
         if (bcr_c) orbit_count <= orbit_count + 32'd1;
         if (issue_c) begin
            l1a_count <= l1a_count + 32'd1;
            dt_cnt    <= l1a_deadtime;
         end else if (dt_cnt != '0) begin
            dt_cnt <= dt_cnt - DT_W'(1);
         end
         if (drop_c && l1a_dropped != 16'hFFFF) l1a_dropped <= l1a_dropped + 16'd1;
      end
   end

endmodule

// File: tb/tb_fc_sequencer.sv
// Directed bench for fc_sequencer: table of word-composition vectors plus hand sequences
// for orbit timing, aligned commands, L1A throttling and asynchronous reset.
module tb_fc_sequencer;

   logic        clk_bx = 1'b0;
   logic        reset = 1'b0;
   logic [11:0] orb_length = 12'd45;
   logic [2:0]  cmd_req = '0;
   logic [2:0]  cmd_align = '0;
   logic [35:0] cmd_bx = '0;
   logic [23:0] l1a_period = '0;
   logic [7:0]  l1a_deadtime = '0;
   logic        busy = 1'b0;
   logic [3:0]  aux_bits = '0;
   logic [15:0] fc_stream_enc;
   logic [11:0] bx_counter;
   logic [31:0] orbit_count, l1a_count;
   logic [15:0] l1a_dropped;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [2:0] req;
      logic [3:0] aux;
      logic       busy;
      logic [7:0] exp;
   } vec_t;
   vec_t vecs [8];

   fc_sequencer dut (
      .clk_bx(clk_bx), .reset(reset), .orb_length(orb_length), .cmd_req(cmd_req),
      .cmd_align(cmd_align), .cmd_bx(cmd_bx), .l1a_period(l1a_period),
      .l1a_deadtime(l1a_deadtime), .busy(busy), .aux_bits(aux_bits),
      .fc_stream_enc(fc_stream_enc), .bx_counter(bx_counter), .orbit_count(orbit_count),
      .l1a_count(l1a_count), .l1a_dropped(l1a_dropped)
   );

   always #5 clk_bx = ~clk_bx;

   // Reference encoder built from codeword positions: parity bit 2**i covers positions with bit i set
   function automatic logic [7:0] ham(input logic [3:0] d);
      logic [7:0] cw;
      cw = '0;
      cw[3] = d[0]; cw[5] = d[1]; cw[6] = d[2]; cw[7] = d[3];
      for (int i = 0; i < 3; i++)
         for (int p = 1; p < 8; p++)
            if (((p >> i) & 1) == 1 && p != (1 << i)) cw[1 << i] = cw[1 << i] ^ cw[p];
      return {^cw[7:1], cw[7:1]};
   endfunction

   function automatic logic [15:0] enc_word(input logic [7:0] w);
      return {ham(w[7:4]), ham(w[3:0])};
   endfunction

   function automatic logic [3:0] low_nibble(input logic [15:0] e);
      return {e[6], e[5], e[4], e[2]};
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge clk_bx);
         #1;
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      cmd_req = '0;
      @(posedge clk_bx);
      #1;
      reset = 1'b0;
   endtask

   task automatic count_bit(input int bitn, input int cycles, output int fires, output int at_bx);
      fires = 0;
      at_bx = -1;
      for (int i = 0; i < cycles; i++) begin
         step();
         if (low_nibble(fc_stream_enc)[bitn]) begin
            fires++;
            at_bx = int'(bx_counter);
         end
      end
   endtask

   initial begin
      int fires, at_bx;
      vecs[0] = '{3'b010, 4'h0, 1'b0, 8'h04};
      vecs[1] = '{3'b000, 4'h0, 1'b0, 8'h00};
      vecs[2] = '{3'b001, 4'h0, 1'b0, 8'h02};
      vecs[3] = '{3'b100, 4'h0, 1'b0, 8'h08};
      vecs[4] = '{3'b111, 4'hA, 1'b0, 8'hAE};
      vecs[5] = '{3'b001, 4'h0, 1'b1, 8'h00};
      vecs[6] = '{3'b000, 4'hF, 1'b0, 8'hF0};
      vecs[7] = '{3'b101, 4'h5, 1'b0, 8'h5A};

      // Reset state
      #1 reset = 1'b1;
      #1;
      check("reset_enc", 64'(fc_stream_enc), 64'h0);
      check("reset_bx", 64'(bx_counter), 64'h0);
      check("reset_cnt", 64'({orbit_count, l1a_count}), 64'h0);
      check("reset_drop", 64'(l1a_dropped), 64'h0);
      @(posedge clk_bx);
      #1 reset = 1'b0;

      // Orbit of 45: BCR at fc_word on edge 1, at the encoded output on edge 2, every 45 BX
      for (int e = 1; e <= 450; e++) begin
         step();
         if (e == 1) check("bx_first", 64'(bx_counter), 64'd1);
         check("bcr_enc", 64'(fc_stream_enc),
               64'(enc_word((e >= 2 && (e - 2) % 45 == 0) ? 8'h01 : 8'h00)));
      end
      check("orbit_count_450", 64'(orbit_count), 64'd10);
      check("bx_after_450", 64'(bx_counter), 64'd0);

      // orb_length = 1: BCR every BX
      orb_length = 12'd1;
      do_reset();
      step(3);
      check("orb1_bx", 64'(bx_counter), 64'd0);
      check("orb1_orbits", 64'(orbit_count), 64'd3);
      check("orb1_enc", 64'(fc_stream_enc), 64'(enc_word(8'h01)));

      // Shrinking orbit below the current BX wraps next cycle
      orb_length = 12'd45;
      do_reset();
      step(30);
      check("pre_shrink_bx", 64'(bx_counter), 64'd30);
      orb_length = 12'd10;
      step();
      check("shrink_wrap", 64'(bx_counter), 64'd0);
      step(9);
      check("shrink_last", 64'(bx_counter), 64'd9);
      step();
      check("shrink_wrap2", 64'(bx_counter), 64'd0);

      // Immediate link reset at bx 5: absent at t+1, present at t+2
      orb_length = 12'd0;
      do_reset();
      step(5);
      cmd_req = 3'b010;
      step();
      cmd_req = '0;
      check("imm_t1", 64'(fc_stream_enc), 64'h0);
      step();
      check("imm_t2", 64'(fc_stream_enc), 64'(enc_word(8'h04)));

      // Word-composition table (deadtime 0, no periodic L1A, never on a BCR)
      for (int i = 0; i < 8; i++) begin
         cmd_req = vecs[i].req;
         aux_bits = vecs[i].aux;
         busy = vecs[i].busy;
         step();
         cmd_req = '0;
         busy = 1'b0;
         step();
         check($sformatf("vec%0d", i), 64'(fc_stream_enc), 64'(enc_word(vecs[i].exp)));
      end
      check("vec_l1a_count", 64'(l1a_count), 64'd3);
      check("vec_l1a_dropped", 64'(l1a_dropped), 64'd1);
      aux_bits = '0;

      // Aligned channel 1 at bx 20, requests at bx 30 and 35 merge into one firing
      orb_length = 12'd45;
      cmd_align = 3'b010;
      cmd_bx = {12'd50, 12'd20, 12'd0};
      do_reset();
      step(30);
      cmd_req = 3'b010;
      step();
      cmd_req = '0;
      step(4);
      check("merge_bx35", 64'(bx_counter), 64'd35);
      cmd_req = 3'b010;
      step();
      cmd_req = '0;
      count_bit(2, 120, fires, at_bx);
      check("aligned_fires", 64'(fires), 64'd1);
      check("aligned_fire_bx", 64'(at_bx), 64'd22);

      // Channel 2 target beyond the orbit stays pending; clearing align releases it
      cmd_align = 3'b100;
      cmd_req = 3'b100;
      step();
      cmd_req = '0;
      count_bit(3, 100, fires, at_bx);
      check("unreachable_fires", 64'(fires), 64'd0);
      cmd_align = '0;
      step();
      check("release_t1", 64'(low_nibble(fc_stream_enc)[3]), 64'd0);
      step();
      check("release_t2", 64'(low_nibble(fc_stream_enc)[3]), 64'd1);
      step();
      check("release_once", 64'(low_nibble(fc_stream_enc)[3]), 64'd0);

      // Periodic L1A every 10 with deadtime 15: every other tick dropped
      l1a_period = 24'd10;
      l1a_deadtime = 8'd15;
      do_reset();
      step(200);
      check("per_l1a_count", 64'(l1a_count), 64'd10);
      check("per_l1a_dropped", 64'(l1a_dropped), 64'd10);

      // Busy for 50 BX with period 5, then resume on the next tick
      l1a_period = 24'd5;
      l1a_deadtime = 8'd0;
      busy = 1'b1;
      do_reset();
      step(50);
      check("busy_count", 64'(l1a_count), 64'd0);
      check("busy_dropped", 64'(l1a_dropped), 64'd10);
      busy = 1'b0;
      step(4);
      check("resume_before", 64'(l1a_count), 64'd0);
      step();
      check("resume_tick", 64'(l1a_count), 64'd1);
      step(4);
      cmd_req = 3'b001;
      step();
      cmd_req = '0;
      check("sw_tick_merge", 64'(l1a_count), 64'd2);
      check("sw_tick_nodrop", 64'(l1a_dropped), 64'd10);
      l1a_period = '0;

      // Asynchronous reset with a pending aligned command
      orb_length = 12'd45;
      cmd_align = 3'b010;
      do_reset();
      step(30);
      cmd_req = 3'b010;
      step();
      cmd_req = '0;
      step(5);
      #2 reset = 1'b1;
      #1;
      check("async_enc", 64'(fc_stream_enc), 64'h0);
      check("async_bx", 64'(bx_counter), 64'h0);
      check("async_cnts", 64'({orbit_count, l1a_count}), 64'h0);
      @(posedge clk_bx);
      #1 reset = 1'b0;
      count_bit(2, 100, fires, at_bx);
      check("async_pending_lost", 64'(fires), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
